// File: rtl/mcb_read_checker.sv
// Read-side pattern checker for an MCB user port: issues NUM_BURSTS read commands,
// drains each burst from the read FIFO and compares every word against an address-derived pattern.
module mcb_read_checker #(
  parameter int          BURST_LEN   = 64,
  parameter int          NUM_BURSTS  = 16,
  parameter logic [29:0] BASE_ADDR   = 30'h0,
  parameter logic [31:0] PATTERN_XOR = 32'hA5A5_5A5A,
  parameter int          TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        calib_done,
  input  logic        start,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_byte_addr,
  input  logic        cmd_full,
  output logic        rd_en,
  input  logic [31:0] rd_data,
  input  logic        rd_empty,
  input  logic        rd_overflow,
  input  logic        rd_error,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] error_count,
  output logic [29:0] first_err_addr
);

  localparam int              IDLE_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LOAD  = IDLE_W'(TIMEOUT - 1);
  localparam logic [6:0]      LAST_WORD    = 7'(BURST_LEN - 1);
  localparam logic [15:0]     LAST_BURST   = 16'(NUM_BURSTS - 1);
  localparam logic [29:0]     BURST_STRIDE = 30'(4 * BURST_LEN);
  localparam logic [5:0]      CMD_BL       = 6'(BURST_LEN - 1);
  localparam logic [2:0]      CMD_READ_AP  = 3'b011;

  typedef enum logic [2:0] {IDLE, CMD, DRAIN, NEXT, FINISH} state_t;

  state_t             state, state_n;
  logic [29:0]        addr_q, addr_n;
  logic [15:0]        burst_q, burst_n;
  logic [6:0]         word_q, word_n;
  logic [IDLE_W-1:0]  idle_q, idle_n;
  logic [15:0]        err_q, err_n;
  logic [29:0]        first_q, first_n;
  logic               timeout_q, timeout_n;
  logic               done_q, done_n;
  logic               pass_q, pass_n;
  logic               fault_q, fault_n;

  logic               pop;
  logic [29:0]        word_addr;
  logic [31:0]        expected;
  logic               mismatch;

  assign pop       = (state == DRAIN) && !rd_empty;
  assign word_addr = addr_q + {21'b0, word_q, 2'b00};
  assign expected  = {2'b00, word_addr} ^ PATTERN_XOR;
  assign mismatch  = pop && (rd_data != expected);

  always_comb begin
    state_n   = state;
    addr_n    = addr_q;
    burst_n   = burst_q;
    word_n    = word_q;
    idle_n    = (state == DRAIN) ? idle_q : IDLE_LOAD;
    err_n     = err_q;
    first_n   = first_q;
    timeout_n = timeout_q;
    done_n    = done_q;
    pass_n    = pass_q;
    fault_n   = fault_q | ((state != IDLE) && (rd_overflow || rd_error));

    case (state)
      IDLE: begin
        if (start && calib_done) begin
          state_n   = CMD;
          addr_n    = BASE_ADDR;
          burst_n   = '0;
          word_n    = '0;
          err_n     = '0;
          first_n   = '0;
          timeout_n = 1'b0;
          done_n    = 1'b0;
          pass_n    = 1'b0;
          fault_n   = 1'b0;
        end
      end
      CMD: begin
        if (!cmd_full) state_n = DRAIN;
      end
      DRAIN: begin
        if (pop) begin
          idle_n = IDLE_LOAD;
          if (mismatch) begin
            if (err_q != 16'hFFFF) err_n = err_q + 16'd1;
            if (err_q == 16'd0) first_n = word_addr;
          end
          if (word_q == LAST_WORD) begin
            word_n  = '0;
            state_n = NEXT;
          end else begin
            word_n = word_q + 7'd1;
          end
        end else if (idle_q == '0) begin
          timeout_n = 1'b1;
          state_n   = FINISH;
        end else begin
          idle_n = idle_q - IDLE_W'(1);
        end
      end
      NEXT: begin
        addr_n = addr_q + BURST_STRIDE;
        if (burst_q == LAST_BURST) begin
          state_n = FINISH;
        end else begin
          burst_n = burst_q + 16'd1;
          state_n = CMD;
        end
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Verdict is frozen on entry to FINISH using the final counter/flag values.
    if (state_n == FINISH && state != FINISH) begin
      done_n = 1'b1;
      pass_n = (err_n == 16'd0) && !fault_n && !timeout_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= BASE_ADDR;
      burst_q   <= '0;
      word_q    <= '0;
      idle_q    <= IDLE_LOAD;
      err_q     <= '0;
      first_q   <= '0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state     <= state_n;
      addr_q    <= addr_n;
      burst_q   <= burst_n;
      word_q    <= word_n;
      idle_q    <= idle_n;
      err_q     <= err_n;
      first_q   <= first_n;
      timeout_q <= timeout_n;
      done_q    <= done_n;
      pass_q    <= pass_n;
      fault_q   <= fault_n;
    end
  end

  assign cmd_en         = (state == CMD) && !cmd_full;
  assign cmd_instr      = CMD_READ_AP;
  assign cmd_bl         = CMD_BL;
  assign cmd_byte_addr  = addr_q;
  assign rd_en          = pop;
  assign busy           = (state == CMD) || (state == DRAIN) || (state == NEXT);
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign error_count    = err_q;
  assign first_err_addr = first_q;

endmodule

// File: tb/tb_mcb_read_checker.sv
// Bench for mcb_read_checker: a behavioural MCB read-port model fills a FIFO on each command,
// expected command addresses are queued per run and popped as commands appear.
module tb_mcb_read_checker;
  localparam logic [31:0] PAT = 32'hA5A5_5A5A;
  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic calib_done = 1'b1;
  logic start_a = 1'b0, start_w = 1'b0;
  logic cmd_full = 1'b0;
  logic rd_empty = 1'b1;
  logic rd_overflow = 1'b0, rd_error = 1'b0;
  logic [31:0] rd_data = 32'h0;
  logic sel = 1'b0;

  logic cmd_en_a, rd_en_a, busy_a, done_a, pass_a, timeout_a;
  logic [2:0] cmd_instr_a; logic [5:0] cmd_bl_a; logic [29:0] cmd_addr_a, first_a; logic [15:0] err_a;
  logic cmd_en_w, rd_en_w, busy_w, done_w, pass_w, timeout_w;
  logic [2:0] cmd_instr_w; logic [5:0] cmd_bl_w; logic [29:0] cmd_addr_w, first_w; logic [15:0] err_w;

  always #5 clk = ~clk;

  mcb_read_checker #(.BURST_LEN(64), .NUM_BURSTS(2), .BASE_ADDR(30'h0), .TIMEOUT(16)) dut_a (
    .clk(clk), .rst(rst), .calib_done(calib_done), .start(start_a),
    .cmd_en(cmd_en_a), .cmd_instr(cmd_instr_a), .cmd_bl(cmd_bl_a), .cmd_byte_addr(cmd_addr_a),
    .cmd_full(cmd_full), .rd_en(rd_en_a), .rd_data(rd_data), .rd_empty(rd_empty),
    .rd_overflow(rd_overflow), .rd_error(rd_error), .busy(busy_a), .done(done_a), .pass(pass_a),
    .timeout(timeout_a), .error_count(err_a), .first_err_addr(first_a));

  mcb_read_checker #(.BURST_LEN(64), .NUM_BURSTS(2), .BASE_ADDR(30'h3FFF_FF00), .TIMEOUT(16)) dut_w (
    .clk(clk), .rst(rst), .calib_done(calib_done), .start(start_w),
    .cmd_en(cmd_en_w), .cmd_instr(cmd_instr_w), .cmd_bl(cmd_bl_w), .cmd_byte_addr(cmd_addr_w),
    .cmd_full(cmd_full), .rd_en(rd_en_w), .rd_data(rd_data), .rd_empty(rd_empty),
    .rd_overflow(rd_overflow), .rd_error(rd_error), .busy(busy_w), .done(done_w), .pass(pass_w),
    .timeout(timeout_w), .error_count(err_w), .first_err_addr(first_w));

  // The FIFO model serves whichever instance is selected; the other one stays idle.
  logic cmd_en_m, rd_en_m, busy_m, done_m, pass_m, timeout_m;
  logic [2:0] cmd_instr_m; logic [5:0] cmd_bl_m; logic [29:0] cmd_addr_m, first_m; logic [15:0] err_m;
  assign cmd_en_m    = sel ? cmd_en_w    : cmd_en_a;
  assign rd_en_m     = sel ? rd_en_w     : rd_en_a;
  assign busy_m      = sel ? busy_w      : busy_a;
  assign done_m      = sel ? done_w      : done_a;
  assign pass_m      = sel ? pass_w      : pass_a;
  assign timeout_m   = sel ? timeout_w   : timeout_a;
  assign cmd_instr_m = sel ? cmd_instr_w : cmd_instr_a;
  assign cmd_bl_m    = sel ? cmd_bl_w    : cmd_bl_a;
  assign cmd_addr_m  = sel ? cmd_addr_w  : cmd_addr_a;
  assign first_m     = sel ? first_w     : first_a;
  assign err_m       = sel ? err_w       : err_a;

  int errors = 0, checks = 0;
  logic [31:0] fifo[$];
  logic [29:0] exp_cmd[$];
  int pop_count, cmd_count, full_viol, pushed, deliver_limit;
  logic [31:0] bad0 = NONE, bad1 = NONE;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: model reacts to the strobes seen at the rising edge, then presents the FIFO head.
  task automatic tick();
    logic [29:0] a;
    logic [31:0] w;
    @(posedge clk);
    if (rd_en_m) begin
      pop_count++;
      if (fifo.size() != 0) void'(fifo.pop_front());
    end
    if (cmd_en_m) begin
      cmd_count++;
      if (cmd_full) full_viol++;
      if (exp_cmd.size() == 0) chk("cmd_extra", 32'd1, 32'd0);
      else chk("cmd_addr", {2'b00, cmd_addr_m}, {2'b00, exp_cmd.pop_front()});
      chk("cmd_instr", {29'b0, cmd_instr_m}, 32'd3);
      chk("cmd_bl", {26'b0, cmd_bl_m}, 32'd63);
      for (int i = 0; i < 64; i++) begin
        a = cmd_addr_m + 30'(4 * i);
        w = {2'b00, a} ^ PAT;
        if ({2'b00, a} == bad0 || {2'b00, a} == bad1) w = w ^ 32'h1;
        if (pushed < deliver_limit) begin
          fifo.push_back(w);
          pushed++;
        end
      end
    end
    @(negedge clk);
    rd_empty = (fifo.size() == 0);
    rd_data  = (fifo.size() != 0) ? fifo[0] : 32'h0;
  endtask

  task automatic prep(input logic [29:0] c0, input logic [29:0] c1, input int ncmd);
    pop_count = 0; cmd_count = 0; full_viol = 0; pushed = 0; deliver_limit = 1 << 20;
    fifo.delete(); exp_cmd.delete();
    exp_cmd.push_back(c0);
    if (ncmd > 1) exp_cmd.push_back(c1);
  endtask

  task automatic run_start();
    if (sel) start_w = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0; start_w = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_m && n < budget) begin tick(); n++; end
    chk("run_done", {31'b0, done_m}, 32'd1);
  endtask

  task automatic wait_pops(input int target);
    int n = 0;
    while (pop_count < target && n < 1000) begin tick(); n++; end
    chk("pops_reached", {31'b0, pop_count >= target}, 32'd1);
  endtask

  initial begin
    int idle, cc, pc;
    repeat (3) tick();
    chk("rst_busy", {31'b0, busy_a}, 0);
    chk("rst_done", {31'b0, done_a}, 0);
    chk("rst_pass", {31'b0, pass_a}, 0);
    chk("rst_timeout", {31'b0, timeout_a}, 0);
    chk("rst_err", {16'b0, err_a}, 0);
    chk("rst_cmd_en", {31'b0, cmd_en_a}, 0);
    chk("rst_rd_en", {31'b0, rd_en_a}, 0);
    chk("rst_instr", {29'b0, cmd_instr_a}, 3);
    chk("rst_bl", {26'b0, cmd_bl_a}, 63);
    chk("rst_addr_a", {2'b0, cmd_addr_a}, 32'h0);
    chk("rst_addr_w", {2'b0, cmd_addr_w}, 32'h3FFF_FF00);
    rst = 1'b0;
    tick();

    // clean two-burst run
    prep(30'h000, 30'h100, 2);
    run_start();
    wait_done(1000);
    chk("clean_pass", {31'b0, pass_m}, 1);
    chk("clean_err", {16'b0, err_m}, 0);
    chk("clean_pops", pop_count, 128);
    chk("clean_cmds", cmd_count, 2);
    chk("clean_timeout", {31'b0, timeout_m}, 0);
    chk("clean_busy", {31'b0, busy_m}, 0);
    chk("clean_cmdq", exp_cmd.size(), 0);

    // leftover FIFO words while idle must stay put
    fifo.push_back(32'h1234); fifo.push_back(32'h5678);
    pc = pop_count;
    repeat (10) tick();
    chk("idle_no_pop", pop_count, pc);
    fifo.delete();
    tick();

    // word 5 of burst 1 corrupted
    prep(30'h000, 30'h100, 2);
    bad0 = 32'h114;
    run_start();
    wait_done(1000);
    chk("bad1_err", {16'b0, err_m}, 1);
    chk("bad1_first", {2'b0, first_m}, 32'h114);
    chk("bad1_pass", {31'b0, pass_m}, 0);
    repeat (5) tick();
    chk("bad1_done_hold", {31'b0, done_m}, 1);
    chk("bad1_err_hold", {16'b0, err_m}, 1);

    // two mismatches: first address kept
    prep(30'h000, 30'h100, 2);
    bad0 = 32'h00C; bad1 = 32'h114;
    run_start();
    wait_done(1000);
    chk("bad2_err", {16'b0, err_m}, 2);
    chk("bad2_first", {2'b0, first_m}, 32'h00C);
    bad0 = NONE; bad1 = NONE;
    tick();

    // command FIFO full for 20 cycles
    prep(30'h000, 30'h100, 2);
    cmd_full = 1'b1;
    run_start();
    repeat (20) tick();
    chk("full_busy", {31'b0, busy_m}, 1);
    chk("full_no_cmd", cmd_count, 0);
    cmd_full = 1'b0;
    wait_done(1000);
    chk("full_cmds", cmd_count, 2);
    chk("full_viol", full_viol, 0);
    chk("full_pass", {31'b0, pass_m}, 1);
    chk("full_pops", pop_count, 128);
    tick();

    // overflow fault mid-run
    prep(30'h000, 30'h100, 2);
    run_start();
    wait_pops(30);
    rd_overflow = 1'b1;
    tick();
    rd_overflow = 1'b0;
    wait_done(1000);
    chk("fault_pass", {31'b0, pass_m}, 0);
    chk("fault_err", {16'b0, err_m}, 0);
    chk("fault_pops", pop_count, 128);
    tick();

    // only 10 words delivered: drain timeout
    prep(30'h000, 30'h100, 1);
    deliver_limit = 10;
    run_start();
    wait_pops(10);
    idle = 0;
    while (!done_m && idle < 100) begin tick(); idle++; end
    chk("to_idle_cycles", idle, 16);
    chk("to_timeout", {31'b0, timeout_m}, 1);
    chk("to_done", {31'b0, done_m}, 1);
    chk("to_pass", {31'b0, pass_m}, 0);
    chk("to_pops", pop_count, 10);
    tick();

    // next clean run clears timeout
    prep(30'h000, 30'h100, 2);
    run_start();
    chk("restart_timeout_clr", {31'b0, timeout_m}, 0);
    chk("restart_done_clr", {31'b0, done_m}, 0);
    wait_done(1000);
    chk("restart_pass", {31'b0, pass_m}, 1);
    tick();

    // reset mid-drain, then start without calibration
    prep(30'h000, 30'h100, 2);
    run_start();
    wait_pops(20);
    rst = 1'b1;
    tick();
    chk("mrst_busy", {31'b0, busy_m}, 0);
    chk("mrst_rd_en", {31'b0, rd_en_m}, 0);
    chk("mrst_done", {31'b0, done_m}, 0);
    chk("mrst_cmd_en", {31'b0, cmd_en_m}, 0);
    rst = 1'b0;
    fifo.delete(); exp_cmd.delete();
    tick();
    calib_done = 1'b0;
    cc = cmd_count;
    run_start();
    repeat (5) tick();
    chk("nocal_busy", {31'b0, busy_m}, 0);
    chk("nocal_cmds", cmd_count, cc);
    calib_done = 1'b1;
    tick();

    // address wrap on the second instance
    sel = 1'b1;
    prep(30'h3FFF_FF00, 30'h000, 2);
    run_start();
    wait_done(1000);
    chk("wrap_pass", {31'b0, pass_m}, 1);
    chk("wrap_cmds", cmd_count, 2);
    chk("wrap_pops", pop_count, 128);
    chk("wrap_cmdq", exp_cmd.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mcb_read_checker.md
MCB_READ_CHECKER -- requirements
Module: mcb_read_checker

Interface
REQ-001 SHALL have parameter BURST_LEN, default 64, meaning words per read command (legal 1..64).
REQ-002 SHALL have parameter NUM_BURSTS, default 16, meaning read commands per run (legal 1..65535).
REQ-003 SHALL have parameter BASE_ADDR, default 30'h0, meaning first byte address (word-aligned).
REQ-004 SHALL have parameter PATTERN_XOR, default 32'hA5A5_5A5A, meaning expected-data scramble constant.
REQ-005 SHALL have parameter TIMEOUT, default 1024, meaning max idle cycles while draining before abort.
REQ-006 SHALL use the following ports, listed one per line as name  direction  width  meaning; clock clk, reset rst (synchronous, active-high).
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
calib_done  in  1  MCB calibration complete.
start  in  1  one-cycle run request.
cmd_en  out  1  command push strobe.
cmd_instr  out  3  command code, always 3'b011 (read, auto-precharge).
cmd_bl  out  6  BURST_LEN-1.
cmd_byte_addr  out  30  burst start byte address.
cmd_full  in  1  command FIFO full.
rd_en  out  1  read FIFO pop.
rd_data  in  32  read FIFO head word, valid while rd_empty=0.
rd_empty  in  1  read FIFO empty.
rd_overflow  in  1  read FIFO overflow.
rd_error  in  1  read FIFO error.
busy  out  1  run in progress.
done  out  1  run finished, sticky until next start or rst.
pass  out  1  valid with done: 1 = zero mismatches, no fault, no timeout.
timeout  out  1  sticky: drain timeout occurred.
error_count  out  16  mismatch count, saturating at 16'hFFFF.
first_err_addr  out  30  byte address of first mismatch.

Function
REQ-007 SHALL implement states IDLE, CMD, DRAIN, NEXT, FINISH.
REQ-008 IDLE -> CMD when start=1 and calib_done=1; clears error_count, first_err_addr, timeout, done, pass, burst and word counters; start while calib_done=0 or not IDLE ignored.
REQ-009 CMD: when cmd_full=0 assert cmd_en for exactly one cycle with cmd_byte_addr = current address, then -> DRAIN; while cmd_full=1 hold, cmd_en=0.
REQ-010 DRAIN: rd_en = 1 exactly in cycles where state=DRAIN and rd_empty=0 (combinational); rd_data sampled in the same cycle.
REQ-011 Expected word for byte address A SHALL be {2'b00, A} XOR PATTERN_XOR; A = burst address + 4*word index.
REQ-012 On mismatch: error_count += 1 (saturating); first_err_addr captured only when error_count was 0.
REQ-013 After BURST_LEN pops -> NEXT; NEXT adds 4*BURST_LEN to address (mod 2^30, wraps silently), increments burst counter, -> FINISH when NUM_BURSTS bursts completed, else -> CMD.
REQ-014 Idle counter resets on every pop; reaching TIMEOUT consecutive DRAIN cycles without pop SHALL set timeout=1 and -> FINISH.
REQ-015 rd_overflow or rd_error sampled high in any non-IDLE state SHALL latch a fault flag (forces pass=0); run continues.
REQ-016 FINISH: done=1, pass = (error_count==0 and no fault and timeout==0), busy=0, -> IDLE in next cycle; done/pass/timeout/error_count hold until next accepted start.
REQ-017 busy=1 in CMD, DRAIN, NEXT; 0 in IDLE, FINISH.
REQ-018 Extra words present in read FIFO outside DRAIN SHALL NOT be popped.

Reset
REQ-019 rst SHALL force IDLE and all outputs 0 (cmd_instr 3'b011, cmd_bl BURST_LEN-1 constant) in the next cycle, including mid-run; no cmd_en or rd_en in the cycle after rst assertion.
REQ-020 Address register SHALL reset to BASE_ADDR.

Verification
REQ-021 BURST_LEN=64, NUM_BURSTS=2, model returns correct pattern -> exactly 2 cmd_en pulses at 0x000, 0x100; 128 pops; done=1, pass=1, error_count=0.
REQ-022 Corrupt word index 5 of burst 1 -> error_count=1, first_err_addr=0x114, pass=0.
REQ-023 Hold cmd_full=1 for 20 cycles during CMD -> cmd_en stays 0, then single pulse after release; result unchanged.
REQ-024 Model delivers only 10 words, TIMEOUT=16 -> timeout=1, done=1, pass=0 at 16th idle cycle.
REQ-025 BASE_ADDR=30'h3FFF_FF00, NUM_BURSTS=2 -> second command at 0x000 (wrap), pass=1.
REQ-026 Assert rst mid-DRAIN -> next cycle busy=0, rd_en=0, done=0; start ignored while calib_done=0.
